// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and round-robin pick helper for fifo_wr_arbiter
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;

  localparam int MAX_REQ = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  // First valid index at or after ptr, searching upward with modulo-nreq wrap.
  // The wrap uses an explicit compare so non-power-of-2 nreq works.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [3:0] ptr,
                                    input int nreq);
    pick_t p;
    int    j;
    p.found = 1'b0;
    p.idx   = 4'd0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < nreq) begin
        j = int'(ptr) + k;
        if (j >= nreq) j = j - nreq;
        if (!p.found && valid[j[3:0]]) begin
          p.found = 1'b1;
          p.idx   = j[3:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_pick.sv
// rtl/fifo_wr_arbiter_pick.sv - masked priority encoder producing a one-hot round-robin grant
module rr_pick_onehot #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt
);

  logic [N-1:0] masked;
  logic [N-1:0] low_masked;
  logic [N-1:0] low_plain;

  // Lowest set bit at or above ptr; fall back to the lowest set bit overall.
  always_comb begin
    masked = '0;
    for (int i = 0; i < N; i++) begin
      masked[i] = req[i] & (i >= int'(ptr));
    end
    low_masked = masked & (~masked + 1'b1);
    low_plain  = req & (~req + 1'b1);
    gnt        = (masked != '0) ? low_masked : low_plain;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write arbiter with burst lock; stats via FIFO_ARB_STATS_EN
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DWIDTH    = 16,
  parameter int BURST_LEN = 4,
  parameter int CNTW      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [DWIDTH-1:0]        fifo_wr_data,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                     stat_clr,
  output logic [NREQ*CNTW-1:0]     stat_cnt
`endif
);

  localparam int IDW = $clog2(NREQ);
  localparam int BCW = $clog2(BURST_LEN + 1);

  arb_state_t       state, state_n;
  logic [IDW-1:0]   rr_ptr, rr_ptr_n;
  logic [IDW-1:0]   lock_id, lock_id_n;
  logic [BCW-1:0]   burst_cnt, burst_cnt_n;
  logic [NREQ-1:0]  pick_gnt;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   gid;
  logic [DWIDTH-1:0] mux_data;
  logic             accept;
  pick_t            pick;

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] x);
    return (x == IDW'(NREQ - 1)) ? '0 : x + 1'b1;
  endfunction

  rr_pick_onehot #(.N(NREQ), .IDW(IDW)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt)
  );

  // Grant selection: round-robin pick in IDLE, fixed to the lock owner in LOCK.
  always_comb begin
    pick     = rr_pick(MAX_REQ'(req_valid), 4'(rr_ptr), NREQ);
    grant    = '0;
    gid      = '0;
    mux_data = '0;
    if (state == ARB_IDLE) begin
      grant = pick.found ? pick_gnt : '0;
      gid   = IDW'(pick.idx);
    end else begin
      gid            = lock_id;
      grant[lock_id] = req_valid[lock_id];
    end
    accept = (|grant) && !fifo_full;
    for (int i = 0; i < NREQ; i++) begin
      if (gid == IDW'(i)) mux_data = req_data[i*DWIDTH +: DWIDTH];
    end
  end

  // Outputs are forced low while reset is asserted so they drop without waiting for a clock.
  always_comb begin
    req_ready    = (rst || fifo_full) ? '0 : grant;
    fifo_wr_en   = accept && !rst;
    fifo_wr_data = (accept && !rst) ? mux_data : '0;
    grant_id     = rst ? '0 : gid;
    busy         = (state == ARB_LOCK) && !rst;
  end

  // Next-state: start a burst on accept, end it on the last beat or when the owner drops valid.
  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    lock_id_n   = lock_id;
    burst_cnt_n = burst_cnt;
    if (state == ARB_IDLE) begin
      if (accept) begin
        if (BURST_LEN == 1) begin
          rr_ptr_n = next_idx(gid);
        end else begin
          lock_id_n   = gid;
          burst_cnt_n = BCW'(1);
          state_n     = ARB_LOCK;
        end
      end
    end else begin
      if (!req_valid[lock_id]) begin
        state_n     = ARB_IDLE;
        rr_ptr_n    = next_idx(lock_id);
        burst_cnt_n = '0;
      end else if (accept) begin
        if (burst_cnt == BCW'(BURST_LEN - 1)) begin
          state_n     = ARB_IDLE;
          rr_ptr_n    = next_idx(lock_id);
          burst_cnt_n = '0;
        end else begin
          burst_cnt_n = burst_cnt + 1'b1;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      lock_id   <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      lock_id   <= lock_id_n;
      burst_cnt <= burst_cnt_n;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [CNTW-1:0] cnt_q [NREQ];

  // Per-requester accepted-beat counters; clear wins over increment, saturate at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (stat_clr) begin
          cnt_q[i] <= '0;
        end else if (req_valid[i] && req_ready[i] && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    assign stat_cnt[g*CNTW +: CNTW] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - bench for fifo_wr_arbiter (BURST_LEN 1 and 4 side by side)
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic        fifo_full;
  logic [3:0]  ready [2];
  logic        wr_en [2];
  logic [15:0] wdata [2];
  logic [1:0]  gid   [2];
  logic        busy  [2];
`ifdef FIFO_ARB_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_cnt [2];
`endif

  int n_pass;
  int n_total;

  bit  m_locked [2];
  int  m_ptr    [2];
  int  m_owner  [2];
  int  m_beats  [2];
  int  bl       [2];

  logic [1:0] o_gid   [2];
  logic       o_busy  [2];
  logic       o_wr    [2];
  logic [3:0] o_ready [2];

  int exp_g3 [8];
  int exp_b3 [8];

  fifo_wr_arbiter #(.NREQ(4), .DWIDTH(16), .BURST_LEN(1), .CNTW(4)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready[0]), .fifo_full(fifo_full), .fifo_wr_en(wr_en[0]),
    .fifo_wr_data(wdata[0]), .grant_id(gid[0]), .busy(busy[0])
`ifdef FIFO_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_cnt(stat_cnt[0])
`endif
  );

  fifo_wr_arbiter #(.NREQ(4), .DWIDTH(16), .BURST_LEN(4), .CNTW(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready[1]), .fifo_full(fifo_full), .fifo_wr_en(wr_en[1]),
    .fifo_wr_data(wdata[1]), .grant_id(gid[1]), .busy(busy[1])
`ifdef FIFO_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_cnt(stat_cnt[1])
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_locked[d] = 1'b0;
      m_ptr[d]    = 0;
      m_owner[d]  = 0;
      m_beats[d]  = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 4'hF;
    fifo_full = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_wr_en[%0d]", d), 32'(wr_en[d]), 32'(0));
      chk($sformatf("rst_ready[%0d]", d), 32'(ready[d]), 32'(0));
      chk($sformatf("rst_gid[%0d]", d), 32'(gid[d]), 32'(0));
      chk($sformatf("rst_busy[%0d]", d), 32'(busy[d]), 32'(0));
      chk($sformatf("rst_data[%0d]", d), 32'(wdata[d]), 32'(0));
    end
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'h0;
    model_reset();
  endtask

  // One clock: drive at negedge, compare against the reference model, advance the model at posedge.
  task automatic step(input logic [3:0] v, input logic f);
    bit has [2];
    int g   [2];
    bit we  [2];
    @(negedge clk);
    req_valid = v;
    fifo_full = f;
    for (int i = 0; i < 4; i++) req_data[i*16 +: 16] = 16'($urandom);
    #1;
    for (int d = 0; d < 2; d++) begin
      has[d] = 1'b0;
      g[d]   = 0;
      if (m_locked[d]) begin
        has[d] = v[m_owner[d]];
        g[d]   = m_owner[d];
      end else begin
        for (int k = 0; k < 4; k++) begin
          int idx;
          idx = (m_ptr[d] + k) % 4;
          if (!has[d] && v[idx]) begin
            has[d] = 1'b1;
            g[d]   = idx;
          end
        end
      end
      we[d] = has[d] && !f;
      chk($sformatf("wr_en[%0d]", d), 32'(wr_en[d]), 32'(we[d]));
      chk($sformatf("req_ready[%0d]", d), 32'(ready[d]), we[d] ? (32'(1) << g[d]) : 32'(0));
      chk($sformatf("busy[%0d]", d), 32'(busy[d]), 32'(m_locked[d]));
      chk($sformatf("wr_data[%0d]", d), 32'(wdata[d]), we[d] ? 32'(req_data[g[d]*16 +: 16]) : 32'(0));
      if (we[d]) chk($sformatf("grant_id[%0d]", d), 32'(gid[d]), 32'(g[d]));
      o_gid[d]   = gid[d];
      o_busy[d]  = busy[d];
      o_wr[d]    = wr_en[d];
      o_ready[d] = ready[d];
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (m_locked[d]) begin
        if (!v[m_owner[d]]) begin
          m_locked[d] = 1'b0;
          m_ptr[d]    = (m_owner[d] + 1) % 4;
        end else if (we[d]) begin
          m_beats[d]++;
          if (m_beats[d] == bl[d]) begin
            m_locked[d] = 1'b0;
            m_ptr[d]    = (m_owner[d] + 1) % 4;
          end
        end
      end else if (we[d]) begin
        if (bl[d] == 1) begin
          m_ptr[d] = (g[d] + 1) % 4;
        end else begin
          m_locked[d] = 1'b1;
          m_owner[d]  = g[d];
          m_beats[d]  = 1;
        end
      end
    end
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    bl[0]     = 1;
    bl[1]     = 4;
    exp_g3    = '{0, 0, 0, 0, 2, 2, 2, 2};
    exp_b3    = '{0, 1, 1, 1, 0, 1, 1, 1};
    rst       = 1'b1;
    req_valid = 4'h0;
    req_data  = '0;
    fifo_full = 1'b0;
`ifdef FIFO_ARB_STATS_EN
    stat_clr  = 1'b0;
`endif
    model_reset();

    // All valid, no burst lock: strict rotation 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(4'hF, 1'b0);
      chk($sformatf("t1_gid%0d", i), 32'(o_gid[0]), 32'(i % 4));
      chk($sformatf("t1_ready%0d", i), 32'(o_ready[0]), 32'(1) << (i % 4));
    end

    // FIFO full for three cycles: nothing written, rotation resumes where it stopped.
    do_reset();
    step(4'hF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(4'hF, 1'b1);
      chk($sformatf("t2_wr%0d", i), 32'(o_wr[0]), 32'(0));
      chk($sformatf("t2_ready%0d", i), 32'(o_ready[0]), 32'(0));
    end
    step(4'hF, 1'b0);
    chk("t2_resume_gid", 32'(o_gid[0]), 32'(1));

    // Bursts of four from req0 then req2.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(4'b0101, 1'b0);
      chk($sformatf("t3_gid%0d", i), 32'(o_gid[1]), 32'(exp_g3[i]));
      chk($sformatf("t3_busy%0d", i), 32'(o_busy[1]), 32'(exp_b3[i]));
    end

    // Owner drops valid mid-burst: release cycle has no grant, pointer moves past owner.
    do_reset();
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b1001, 1'b0);
    chk("t4_release_wr", 32'(o_wr[1]), 32'(0));
    step(4'b1001, 1'b0);
    chk("t4_next_gid", 32'(o_gid[1]), 32'(3));

    // Asynchronous reset between edges during a burst.
    do_reset();
    step(4'hF, 1'b0);
    step(4'hF, 1'b0);
    @(negedge clk);
    req_valid = 4'hF;
    #1;
    chk("t5_pre_wr", 32'(wr_en[1]), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("t5_wr[%0d]", d), 32'(wr_en[d]), 32'(0));
      chk($sformatf("t5_ready[%0d]", d), 32'(ready[d]), 32'(0));
      chk($sformatf("t5_busy[%0d]", d), 32'(busy[d]), 32'(0));
    end
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'h0;
    model_reset();
    step(4'hF, 1'b0);
    chk("t5_restart_gid1", 32'(o_gid[0]), 32'(0));
    chk("t5_restart_gid4", 32'(o_gid[1]), 32'(0));

`ifdef FIFO_ARB_STATS_EN
    // Accept counters: ten beats on req2, clear with a concurrent accept, then saturation.
    do_reset();
    for (int i = 0; i < 10; i++) step(4'b0100, 1'b0);
    #1;
    chk("t6_cnt10", 32'(stat_cnt[0][11:8]), 32'd10);
    chk("t6_cnt_other", 32'(stat_cnt[0][7:0]), 32'd0);
    stat_clr = 1'b1;
    step(4'b0100, 1'b0);
    stat_clr = 1'b0;
    #1;
    chk("t6_cleared", 32'(stat_cnt[0][11:8]), 32'd0);
    for (int i = 0; i < 20; i++) step(4'b0100, 1'b0);
    #1;
    chk("t6_saturate", 32'(stat_cnt[0][11:8]), 32'd15);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
